// File: rtl/neuron_mac_q88.sv
// Streaming signed Q8.8 multiply-accumulate: x = bias + sum(a*w), rounded and held for the sigmoid stage.
// Optional clipping to the Q8.8 range is enabled by defining NEURON_MAC_SAT_EN.
module neuron_mac_q88 #(
  parameter int N_INPUTS = 4,
  parameter int ACC_W    = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_a,
  input  logic signed [15:0] in_w,
  input  logic               in_last,
  input  logic               bias_load,
  input  logic signed [15:0] bias,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_x,
  output logic               out_sat
);

  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);

`ifdef NEURON_MAC_SAT_EN
  localparam int RND_W = ACC_W - 8;
  localparam logic signed [RND_W-1:0] X_MAX = RND_W'(32767);
  localparam logic signed [RND_W-1:0] X_MIN = RND_W'(-32768);
`else
  localparam int RND_W = 16;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ROUND, S_HOLD} state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q;
  logic        [CNT_W-1:0]   count_q;
  logic signed [15:0]        bias_q;
  logic signed [RND_W-1:0]   rnd_q;
  logic                      rnd_v_q;
  logic signed [31:0]        prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic                      accept;
  logic signed [15:0]        x_d;
  logic                      sat_d;

  // Both operands are widened first so the full 32-bit Q16.16 product is kept.
  assign prod     = 32'(in_a) * 32'(in_w);
  assign prod_ext = ACC_W'(prod);
  assign accept   = in_valid && in_ready;

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (in_last || N_INPUTS == 1) ? S_ROUND : S_ACCUM;
      S_ACCUM: if (accept && (in_last || count_q == CNT_LAST)) state_d = S_ROUND;
      S_ROUND: if (rnd_v_q) state_d = S_HOLD;
      S_HOLD:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
`ifdef NEURON_MAC_SAT_EN
    x_d   = rnd_q[15:0];
    sat_d = 1'b0;
    if (rnd_q > X_MAX) begin
      x_d   = 16'sh7FFF;
      sat_d = 1'b1;
    end else if (rnd_q < X_MIN) begin
      x_d   = -16'sh8000;
      sat_d = 1'b1;
    end
`else
    x_d   = rnd_q;
    sat_d = 1'b0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_sat   <= 1'b0;
      acc_q     <= '0;
      count_q   <= '0;
      bias_q    <= '0;
      rnd_q     <= '0;
      rnd_v_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == S_IDLE) || (state_d == S_ACCUM);
      out_valid <= (state_d == S_HOLD);

      // A beat accepted alongside bias_load still sees the old bias_q.
      if (state_q == S_IDLE && bias_load) bias_q <= bias;

      if (accept) begin
        if (state_q == S_IDLE) begin
          acc_q   <= (ACC_W'(bias_q) <<< 8) + prod_ext;
          count_q <= CNT_W'(1);
        end else begin
          acc_q   <= acc_q + prod_ext;
          count_q <= count_q + CNT_W'(1);
        end
      end

      // Round in the first ROUND cycle, clip/wrap into the output registers in the second.
      if (state_q == S_ROUND) begin
        if (!rnd_v_q) begin
          rnd_q   <= RND_W'((acc_q + ACC_W'(128)) >>> 8);
          rnd_v_q <= 1'b1;
        end else begin
          out_x   <= x_d;
          out_sat <= sat_d;
          rnd_v_q <= 1'b0;
        end
      end
    end
  end

endmodule
